frame_buffer_streamer: RTL

//  Reads a stored RGB565 frame from a synchronous-read frame-buffer BRAM in raster order and

---
 rtl/photo_booth_pkg.sv | 22 ++
 rtl/frame_buffer_streamer_read_latency_pipe.sv | 40 ++++
 rtl/frame_buffer_streamer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/photo_booth_pkg.sv
// Shared types and defaults for the photo-booth frame-buffer datapath.
// Pixel format, image geometry defaults and the streamer FSM state encoding.
package photo_booth_pkg;

    localparam int IMG_WIDTH_DEF  = 320;
    localparam int IMG_HEIGHT_DEF = 240;
    localparam int ADDR_W_DEF     = 17;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } fsm_state_t;

endpackage

// File: rtl/frame_buffer_streamer_read_latency_pipe.sv
// Delay line matching the BRAM read latency; MSB of each entry is the valid bit.
// Reports whether any read is still travelling so the streamer knows when it may finish.
module read_latency_pipe
    import photo_booth_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int W     = 18
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_i,
    output logic [W-1:0] out_o,
    output logic         any_valid_o
);

    logic [W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= in_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    always_comb begin
        any_valid_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid_o = any_valid_o | stage_q[i][W-1];
        end
    end

    assign out_o = stage_q[DEPTH-1];

endmodule

// File: rtl/frame_buffer_streamer.sv
// Replays a stored RGB565 frame from a synchronous-read BRAM in raster order
// as the we/wAddr/wData pixel stream consumed by the image filters.
module frame_buffer_streamer
    import photo_booth_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int RD_LATENCY = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              re,
    output logic [ADDR_W-1:0] rAddr,
    input  logic [15:0]       rData,
    output logic              we_out,
    output logic [ADDR_W-1:0] wAddr_out,
    output logic [15:0]       wData_out
);

    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

    fsm_state_t        state_q, state_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              re_q, re_d;
    logic [ADDR_W-1:0] rAddr_q, rAddr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wAddr_q, wAddr_d;
    rgb565_t           wData_q, wData_d;

    logic              issue;
    logic [ADDR_W:0]   tail;
    logic              pipe_any;

    read_latency_pipe #(
        .DEPTH (RD_LATENCY),
        .W     (ADDR_W + 1)
    ) u_pipe (
        .clk         (clk),
        .reset       (reset),
        .in_i        ({re_q, rAddr_q}),
        .out_o       (tail),
        .any_valid_o (pipe_any)
    );

    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        gap_d    = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
        re_d     = 1'b0;
        rAddr_d  = rAddr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        issue    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                    busy_d  = 1'b1;
                    issue   = !stall && (gap_q == '0);
                end
            end
            S_READ: begin
                issue = !stall && (gap_q == '0);
            end
            S_DRAIN: begin
                // re_q is the read launched last cycle, not yet in the delay line
                if (!re_q && !pipe_any) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    gap_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue) begin
            re_d    = 1'b1;
            rAddr_d = rd_cnt_q;
            gap_d   = GAP_LOAD;
            if (rd_cnt_q == LAST_ADDR) begin
                state_d  = S_DRAIN;
                rd_cnt_d = '0;
            end else begin
                rd_cnt_d = rd_cnt_q + 1'b1;
            end
        end

        we_d    = tail[ADDR_W];
        wAddr_d = tail[ADDR_W] ? tail[ADDR_W-1:0] : wAddr_q;
        wData_d = tail[ADDR_W] ? rgb565_t'(rData) : wData_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rd_cnt_q <= '0;
            gap_q    <= '0;
            re_q     <= 1'b0;
            rAddr_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            wAddr_q  <= '0;
            wData_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            gap_q    <= gap_d;
            re_q     <= re_d;
            rAddr_q  <= rAddr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            we_q     <= we_d;
            wAddr_q  <= wAddr_d;
            wData_q  <= wData_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign re        = re_q;
    assign rAddr     = rAddr_q;
    assign we_out    = we_q;
    assign wAddr_out = wAddr_q;
    assign wData_out = wData_q;

endmodule
